// File: rtl/instr_sequencer.sv
// Program store and sequencer feeding the accumulator processor.
// Holds a small loadable program and issues one word per processor fetch
// strobe. instr updates on the fetch edge, so it is stable through the
// following decode cycle when the processor's instruction register captures it.
module instr_sequencer #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               run,
  input  logic               loop_en,
  input  logic               clear,
  input  logic               fetch,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W:0]    prog_len,
  output logic               busy,
  output logic               halted
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  // add #0: leaves the accumulator untouched
  localparam logic [INSTR_W-1:0] NOP = '0;
  localparam logic [ADDR_W:0]    ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]         state, state_nxt;
  logic [ADDR_W-1:0]  pc_nxt;
  logic [INSTR_W-1:0] instr_nxt;
  logic [INSTR_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]    load_end;
  logic               at_last;
  logic               load_ok;

  // Loads only land while idle; a load also blocks a same-cycle run.
  assign load_ok  = (state == S_IDLE) && load_en;
  assign load_end = {1'b0, load_addr} + ONE;
  assign at_last  = ({1'b0, pc} == (prog_len - ONE));

  // Next-state / next-output decode for the sequencer.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr;
    case (state)
      S_IDLE: begin
        if (!load_en && run && (prog_len != '0)) begin
          state_nxt = S_RUN;
          pc_nxt    = '0;
        end
      end
      S_RUN: begin
        if (clear) begin
          state_nxt = S_IDLE;
          pc_nxt    = '0;
          instr_nxt = NOP;
        end else if (fetch) begin
          instr_nxt = mem[pc];
          if (!at_last) begin
            pc_nxt = pc + 1'b1;
          end else if (loop_en) begin
            pc_nxt = '0;
          end else begin
            state_nxt = S_HALT;
          end
        end
      end
      S_HALT: begin
        if (clear) begin
          state_nxt = S_IDLE;
          pc_nxt    = '0;
          instr_nxt = NOP;
        end else if (fetch) begin
          instr_nxt = NOP;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        pc_nxt    = '0;
        instr_nxt = NOP;
      end
    endcase
  end

  // Sequencer registers; busy/halted are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      pc     <= '0;
      instr  <= NOP;
      busy   <= 1'b0;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      instr  <= instr_nxt;
      busy   <= (state_nxt == S_RUN);
      halted <= (state_nxt == S_HALT);
    end
  end

  // Program length tracks the highest address written; reset erases it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_len <= '0;
    end else if (load_ok && (load_end > prog_len)) begin
      prog_len <= load_end;
    end
  end

  // Program store; reset clears every word so stale programs never reissue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (load_ok) begin
      mem[load_addr] <= load_data;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: the driver updates a behavioural
// model on every clock and queues the expected outputs for each fetch; a
// monitor pops and compares after every fetch edge.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [10:0] load_data = '0;
  logic        run = 1'b0;
  logic        loop_en = 1'b0;
  logic        clear = 1'b0;
  logic        fetch = 1'b0;
  logic [10:0] instr;
  logic [3:0]  pc;
  logic [4:0]  prog_len;
  logic        busy;
  logic        halted;

  instr_sequencer #(.DEPTH(16), .ADDR_W(4), .INSTR_W(11)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .run(run), .loop_en(loop_en), .clear(clear),
    .fetch(fetch), .instr(instr), .pc(pc), .prog_len(prog_len),
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] instr;
    logic [3:0]  pc;
    logic [4:0]  plen;
    logic        busy;
    logic        halted;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  // behavioural model: program as an array, mode as a small integer
  logic [10:0] m_prog [16];
  int          m_len;
  int          m_mode;   // 0 idle, 1 running, 2 halted
  int          m_pc;
  logic [10:0] m_instr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_prog[i] = '0;
    m_len = 0; m_mode = 0; m_pc = 0; m_instr = '0;
  endfunction

  // Applies this cycle's inputs to the model as the coming edge will.
  function automatic void model_step();
    if (m_mode == 0) begin
      if (load_en) begin
        m_prog[load_addr] = load_data;
        if (int'(load_addr) + 1 > m_len) m_len = int'(load_addr) + 1;
      end else if (run && m_len != 0) begin
        m_mode = 1; m_pc = 0;
      end
    end else if (clear) begin
      m_mode = 0; m_pc = 0; m_instr = '0;
    end else if (fetch) begin
      if (m_mode == 2) m_instr = '0;
      else begin
        m_instr = m_prog[m_pc];
        if (m_pc == m_len - 1) begin
          if (loop_en) m_pc = 0; else m_mode = 2;
        end else m_pc = m_pc + 1;
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.instr = m_instr; e.pc = 4'(m_pc); e.plen = 5'(m_len);
    e.busy = (m_mode == 1); e.halted = (m_mode == 2);
    return e;
  endfunction

  // One clock: model and scoreboard see the inputs, then pulses drop.
  task automatic tick();
    model_step();
    if (fetch) sb.push_back(model_out());
    @(negedge clk);
    load_en = 1'b0; run = 1'b0; clear = 1'b0; fetch = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] a, input logic [10:0] d);
    load_en = 1'b1; load_addr = a; load_data = d; tick();
  endtask

  task automatic do_run();
    run = 1'b1; tick();
  endtask

  // Processor-like cadence: fetch, decode, execute.
  task automatic do_fetch3();
    fetch = 1'b1; tick(); tick(); tick();
  endtask

  task automatic do_clear();
    clear = 1'b1; tick();
  endtask

  task automatic hard_reset();
    rst_n = 1'b0; #1; model_reset(); @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic chk_state(input string tag);
    exp_t e;
    e = model_out();
    chk({tag, "_instr"}, 32'(instr), 32'(e.instr));
    chk({tag, "_pc"}, 32'(pc), 32'(e.pc));
    chk({tag, "_plen"}, 32'(prog_len), 32'(e.plen));
    chk({tag, "_busy"}, 32'(busy), 32'(e.busy));
    chk({tag, "_halted"}, 32'(halted), 32'(e.halted));
  endtask

  // Monitor: after every fetch edge compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (fetch === 1'b1 && rst_n === 1'b1) begin
        #1;
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb_underflow: fetch seen with no expectation queued");
        end else begin
          e = sb.pop_front();
          chk("mon_instr", 32'(instr), 32'(e.instr));
          chk("mon_pc", 32'(pc), 32'(e.pc));
          chk("mon_plen", 32'(prog_len), 32'(e.plen));
          chk("mon_busy", 32'(busy), 32'(e.busy));
          chk("mon_halted", 32'(halted), 32'(e.halted));
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state, fetches and run with an empty program
    chk("rst_instr", 32'(instr), 32'h000);
    chk("rst_plen", 32'(prog_len), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    repeat (2) do_fetch3();
    do_run();
    chk("run_empty_busy", 32'(busy), 32'h0);
    do_fetch3();

    // three-word program, no loop: 401 003 105 then NOPs
    do_load(4'd0, 11'h401);
    do_load(4'd1, 11'h003);
    do_load(4'd2, 11'h105);
    chk("plen3", 32'(prog_len), 32'd3);
    loop_en = 1'b0;
    do_run();
    chk_state("run3");
    repeat (5) do_fetch3();
    chk("halt3", 32'(halted), 32'h1);
    do_clear();
    chk_state("clr_halt");

    // same program looping
    loop_en = 1'b1;
    do_run();
    repeat (5) do_fetch3();
    chk("loop_busy", 32'(busy), 32'h1);
    do_clear();

    // only the last address loaded: 15 NOPs then the word, then halt
    hard_reset();
    loop_en = 1'b0;
    do_load(4'd15, 11'h2A5);
    chk("plen16", 32'(prog_len), 32'd16);
    do_run();
    repeat (17) do_fetch3();
    chk_state("halt16");

    // load and run together: load wins
    hard_reset();
    load_en = 1'b1; load_addr = 4'd2; load_data = 11'h7FF; run = 1'b1; tick();
    chk_state("load_run");
    do_run();
    repeat (2) do_fetch3();
    // clear beats a simultaneous fetch
    clear = 1'b1; fetch = 1'b1; tick();
    chk_state("clr_fetch");

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      load_en   = ($urandom_range(0, 9) < 3);
      load_addr = 4'($urandom_range(0, 15));
      load_data = 11'($urandom);
      run       = ($urandom_range(0, 9) < 2);
      loop_en   = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 49) == 0);
      fetch     = (c % 3 == 0);
      tick();
      if (c == 700) hard_reset();
    end
    chk_state("rand_end");

    // asynchronous reset mid-run, between edges
    hard_reset();
    do_load(4'd0, 11'h401);
    do_load(4'd1, 11'h003);
    loop_en = 1'b1;
    do_run();
    do_fetch3();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_state("async_rst");
    rst_n = 1'b1;
    @(negedge clk);
    do_run();
    chk("post_rst_run_busy", 32'(busy), 32'h0);
    do_fetch3();
    chk_state("post_rst");

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
